// File: rtl/duck_sprite_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : duck_sprite_fetch
//  Purpose  : Sprite ROM address generation and colour-index registration for
//             the duck sprite. Shadows the duck state once per frame so a frame
//             never tears, and owns the animation frame counter.
//             Fixed 3-cycle latency from raster position to pix_index/pix_hit.
//  Revision : 1.0  initial release
// ============================================================================
module duck_sprite_fetch #(
    parameter int          SPRITE_W        = 32,
    parameter int          SPRITE_H        = 32,
    parameter int          NUM_FRAMES      = 4,
    parameter int          FRAME_TICKS     = 8,
    parameter int          ADDR_W          = 12,
    parameter logic [3:0]  TRANSPARENT_IDX = 4'd0,
    localparam int         FS_W            = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              de,
    input  logic              frame_start,
    input  logic [9:0]        duck_x,
    input  logic [9:0]        duck_y,
    input  logic              duck_en,
    input  logic              flip,
    input  logic              anim_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pix_index,
    output logic              pix_hit,
    output logic [FS_W-1:0]   frame_sel
);

    localparam int TICK_W      = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int FRAME_WORDS = SPRITE_W * SPRITE_H;

    // Per-frame shadow of the live duck state
    logic [9:0]        r_sx;
    logic [9:0]        r_sy;
    logic              r_sflip;
    logic              r_sen;
    logic [TICK_W-1:0] r_tick;

    // Pipeline valid bits
    logic              r_v1;
    logic              r_v2;

    // Stage-1 combinational terms
    logic [10:0]       w_x_end;
    logic [10:0]       w_y_end;
    logic              w_inside;
    logic [9:0]        w_rx;
    logic [9:0]        w_ry;
    logic [9:0]        w_col;
    logic [ADDR_W-1:0] w_addr;
    logic              w_hit_next;

    // Sprite extents are compared at 11 bits so an edge-hugging sprite clips
    // rather than wrapping back to column/row 0.
    assign w_x_end  = {1'b0, r_sx} + 11'(SPRITE_W);
    assign w_y_end  = {1'b0, r_sy} + 11'(SPRITE_H);
    assign w_inside = de & r_sen
                    & (draw_x >= r_sx) & ({1'b0, draw_x} < w_x_end)
                    & (draw_y >= r_sy) & ({1'b0, draw_y} < w_y_end);

    assign w_rx  = draw_x - r_sx;
    assign w_ry  = draw_y - r_sy;
    assign w_col = r_sflip ? (10'(SPRITE_W - 1) - w_rx) : w_rx;

    // Constant multipliers collapse to shifts for power-of-two sizes but stay
    // exact for any size.
    assign w_addr = ADDR_W'(frame_sel) * ADDR_W'(FRAME_WORDS)
                  + ADDR_W'(w_ry) * ADDR_W'(SPRITE_W)
                  + ADDR_W'(w_col);

    assign w_hit_next = r_v2 & (rom_data != TRANSPARENT_IDX);

    // Latch the duck state once per frame; pixels on the same edge still see
    // the old values because stage 1 reads the registers before this update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sx    <= '0;
            r_sy    <= '0;
            r_sflip <= 1'b0;
            r_sen   <= 1'b0;
        end else if (frame_start) begin
            r_sx    <= duck_x;
            r_sy    <= duck_y;
            r_sflip <= flip;
            r_sen   <= duck_en;
        end
    end

    // Animation: advance one frame every FRAME_TICKS enabled frame_start pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick    <= '0;
            frame_sel <= '0;
        end else if (frame_start && anim_en) begin
            if (r_tick == TICK_W'(FRAME_TICKS - 1)) begin
                r_tick <= '0;
                if (frame_sel == FS_W'(NUM_FRAMES - 1)) begin
                    frame_sel <= '0;
                end else begin
                    frame_sel <= frame_sel + 1'b1;
                end
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

    // Stage 1 and 2: issue the ROM address and track validity alongside the ROM read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
        end else begin
            rom_addr <= w_inside ? w_addr : '0;
            r_v1     <= w_inside;
            r_v2     <= r_v1;
        end
    end

    // Stage 3: register the colour index; transparent or outside pixels miss
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_hit   <= 1'b0;
            pix_index <= TRANSPARENT_IDX;
        end else begin
            pix_hit   <= w_hit_next;
            pix_index <= w_hit_next ? rom_data : TRANSPARENT_IDX;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_duck_sprite_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_duck_sprite_fetch
//  Purpose  : Self-checking bench for duck_sprite_fetch with a behavioural
//             model of sprite placement, animation and ROM lookup.
//  Revision : 1.0  initial release
// ============================================================================
module tb_duck_sprite_fetch;

    localparam int SW = 32;
    localparam int SH = 32;
    localparam int NF = 4;
    localparam int FT = 8;
    localparam int AW = 12;

    logic          clk;
    logic          reset_n;
    logic [9:0]    draw_x, draw_y;
    logic          de, frame_start;
    logic [9:0]    duck_x, duck_y;
    logic          duck_en, flip, anim_en;
    logic [AW-1:0] rom_addr;
    logic [3:0]    rom_data;
    logic [3:0]    pix_index;
    logic          pix_hit;
    logic [1:0]    frame_sel;

    duck_sprite_fetch #(
        .SPRITE_W(SW), .SPRITE_H(SH), .NUM_FRAMES(NF), .FRAME_TICKS(FT),
        .ADDR_W(AW), .TRANSPARENT_IDX(4'd0)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .draw_x(draw_x), .draw_y(draw_y), .de(de), .frame_start(frame_start),
        .duck_x(duck_x), .duck_y(duck_y), .duck_en(duck_en), .flip(flip),
        .anim_en(anim_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_index(pix_index), .pix_hit(pix_hit), .frame_sel(frame_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous sprite ROM: word i holds (i mod 16) xor 5, so word 0 = 5
    // and every word whose low nibble is 5 is transparent.
    logic [3:0] rom [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 4'(i) ^ 4'h5;
    end
    always @(posedge clk) rom_data <= rom[rom_addr];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_sx, m_sy, m_sflip, m_sen;
    int m_pulses;          // enabled frame_start pulses since reset
    int m_frame;
    int e_addr;
    int h_hit [0:2];       // expected pixel results, newest first
    int h_idx [0:2];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_sx = 0; m_sy = 0; m_sflip = 0; m_sen = 0;
            m_pulses = 0; m_frame = 0; e_addr = 0;
            for (int k = 0; k < 3; k++) begin h_hit[k] = 0; h_idx[k] = 0; end
        end else begin
            int x, y, col, addr, ins;
            x = int'(draw_x); y = int'(draw_y);
            ins = (de && m_sen != 0 && x >= m_sx && x < m_sx + SW
                   && y >= m_sy && y < m_sy + SH) ? 1 : 0;
            col  = (m_sflip != 0) ? (SW - 1 - (x - m_sx)) : (x - m_sx);
            addr = (ins != 0) ? (m_frame * SW * SH + (y - m_sy) * SW + col) : 0;
            e_addr = addr;
            h_hit[2] = h_hit[1]; h_idx[2] = h_idx[1];
            h_hit[1] = h_hit[0]; h_idx[1] = h_idx[0];
            h_hit[0] = (ins != 0 && rom[addr] != 4'd0) ? 1 : 0;
            h_idx[0] = (h_hit[0] != 0) ? int'(rom[addr]) : 0;
            if (frame_start) begin
                m_sx = int'(duck_x); m_sy = int'(duck_y);
                m_sflip = int'(flip); m_sen = int'(duck_en);
                if (anim_en) m_pulses++;
            end
            m_frame = (m_pulses / FT) % NF;
        end
    end

    // Every-cycle comparison against the model, half a cycle after the edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("model rom_addr",  int'(rom_addr),  e_addr);
            check("model pix_hit",   int'(pix_hit),   h_hit[2]);
            check("model pix_index", int'(pix_index), h_idx[2]);
            check("model frame_sel", int'(frame_sel), m_frame);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int x, input int y, input bit d, input bit fs);
        draw_x = 10'(x); draw_y = 10'(y); de = d; frame_start = fs;
        @(posedge clk); #1;
    endtask

    task automatic pulse();
        drive(0, 0, 1'b0, 1'b1);
        drive(0, 0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 1'b0, 1'b0);
    endtask

    task automatic sweep(input int x0, input int x1, input int y);
        for (int x = x0; x <= x1; x++) drive(x, y, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        draw_x = '0; draw_y = '0; de = 1'b0; frame_start = 1'b0;
        duck_x = '0; duck_y = '0; duck_en = 1'b0; flip = 1'b0; anim_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset rom_addr",  int'(rom_addr),  0);
        check("reset pix_hit",   int'(pix_hit),   0);
        check("reset pix_index", int'(pix_index), 0);
        check("reset frame_sel", int'(frame_sel), 0);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        idle(2);

        // Basic placement at (100,50), no flip
        duck_x = 10'd100; duck_y = 10'd50; duck_en = 1'b1; flip = 1'b0;
        pulse();
        drive(100, 50, 1'b1, 1'b0);
        check("lit addr (100,50)", int'(rom_addr), 0);
        drive(131, 50, 1'b1, 1'b0);
        check("lit addr (131,50)", int'(rom_addr), 31);
        drive(132, 50, 1'b1, 1'b0);
        check("lit addr (132,50)", int'(rom_addr), 0);
        check("lit pix_index ROM[0]", int'(pix_index), 5);
        check("lit pix_hit (100,50)", int'(pix_hit), 1);
        idle(2);
        check("lit pix_hit (132,50)", int'(pix_hit), 0);
        sweep(95, 135, 50);
        sweep(95, 135, 81);
        sweep(95, 135, 82);
        idle(3);

        // Mirrored
        flip = 1'b1;
        pulse();
        drive(100, 50, 1'b1, 1'b0);
        check("lit flip addr (100,50)", int'(rom_addr), 31);
        drive(131, 50, 1'b1, 1'b0);
        check("lit flip addr (131,50)", int'(rom_addr), 0);
        drive(100, 51, 1'b1, 1'b0);
        check("lit flip addr (100,51)", int'(rom_addr), 63);
        sweep(98, 134, 60);
        idle(3);

        // Animation: frame 1 after 8 pulses, wrap after 32
        flip = 1'b0; anim_en = 1'b1;
        for (int p = 0; p < 7; p++) pulse();
        check("lit frame_sel after 7", int'(frame_sel), 0);
        pulse();
        check("lit frame_sel after 8", int'(frame_sel), 1);
        drive(100, 50, 1'b1, 1'b0);
        check("lit frame1 addr (100,50)", int'(rom_addr), 1024);
        sweep(99, 133, 70);
        for (int p = 0; p < 24; p++) pulse();
        check("lit frame_sel after 32", int'(frame_sel), 0);
        anim_en = 1'b0;
        pulse();
        check("lit frame_sel hold", int'(frame_sel), 0);

        // Live position change without frame_start must not move the sprite
        duck_x = 10'd200;
        drive(100, 60, 1'b1, 1'b0);
        idle(2);
        check("lit old shadow hit", int'(pix_hit), 1);
        sweep(95, 240, 60);
        pulse();
        drive(200, 60, 1'b1, 1'b0);
        check("lit new shadow addr", int'(rom_addr), 320);
        sweep(95, 240, 60);
        idle(3);

        // Right-edge clipping and transparent word
        duck_x = 10'd620;
        pulse();
        sweep(600, 639, 50);
        sweep(0, 15, 50);
        drive(625, 50, 1'b1, 1'b0);
        check("lit clip addr (625,50)", int'(rom_addr), 5);
        idle(2);
        check("lit transparent hit", int'(pix_hit), 0);
        check("lit transparent index", int'(pix_index), 0);
        drive(630, 50, 1'b0, 1'b0);
        check("lit de=0 addr", int'(rom_addr), 0);
        idle(3);

        // Mid-sprite asynchronous reset
        duck_x = 10'd100; anim_en = 1'b1;
        for (int p = 0; p < 8; p++) pulse();
        sweep(100, 105, 50);
        #3;
        reset_n = 1'b0;
        #1;
        check("lit async pix_hit", int'(pix_hit), 0);
        check("lit async frame_sel", int'(frame_sel), 0);
        check("lit async rom_addr", int'(rom_addr), 0);
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        anim_en = 1'b0;
        pulse();
        drive(100, 50, 1'b1, 1'b0);
        check("lit refill t+1", int'(pix_hit), 0);
        drive(101, 50, 1'b1, 1'b0);
        check("lit refill t+2", int'(pix_hit), 0);
        drive(102, 50, 1'b1, 1'b0);
        check("lit refill t+3", int'(pix_hit), 1);
        idle(4);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
